// File: rtl/qbus_dma_if.sv
// Host-side request/response interface for the Q-bus DMA master.
//   req/we/addr/wdata : one-shot transfer request from the host
//   busy/done/nxm     : transfer status; done is a single-clock pulse, nxm valid with it
//   rdata             : read result, held from done until the next accepted request
interface qbus_dma_if;
  logic        req;
  logic        we;
  logic [21:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        nxm;
  logic [15:0] rdata;

  modport master (output req, we, addr, wdata, input busy, done, nxm, rdata);
  modport slave  (input req, we, addr, wdata, output busy, done, nxm, rdata);
endinterface

// File: rtl/qbus_dma.sv
// Q-bus DMA master: performs one DATI (read) or DATO (write) cycle per host
// request, including DMA arbitration (DMR/DMG/SACK) and NXM timeout.
//   clk, reset_n        : system clock, async active-low reset
//   host                : request/status interface (qbus_dma_if.slave)
//   DAL / DALtx         : shared address/data lines and their direction (1 = we drive)
//   RRPLY RSYNC RDMGI RINIT : received bus signals, already synchronous to clk
//   TSYNC TDIN TDOUT TWTBT TDMR TSACK TDMGO : transmitted bus signals
module qbus_dma #(
  parameter int ADDR_SETUP  = 15,
  parameter int DESKEW      = 10,
  parameter int DATA_SETUP  = 10,
  parameter int RPLY_DLY    = 15,
  parameter int NXM_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  qbus_dma_if.slave  host,
  inout  tri  [21:0] DAL,
  output logic       DALtx,
  input  logic       RRPLY,
  input  logic       RSYNC,
  input  logic       RDMGI,
  input  logic       RINIT,
  output logic       TSYNC,
  output logic       TDIN,
  output logic       TDOUT,
  output logic       TWTBT,
  output logic       TDMR,
  output logic       TSACK,
  output logic       TDMGO
);

  function automatic int maxi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = maxi(maxi(maxi(ADDR_SETUP, DESKEW), maxi(DATA_SETUP, RPLY_DLY)), NXM_TIMEOUT);
  localparam int CW   = maxi($clog2(MAXP + 1), 10);

  localparam logic [CW-1:0] AS_LAST = CW'(ADDR_SETUP - 1);
  localparam logic [CW-1:0] DK_LAST = CW'(DESKEW - 1);
  localparam logic [CW-1:0] DS_LAST = CW'(DATA_SETUP - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RPLY_DLY - 1);
  localparam logic [CW-1:0] NT_LAST = CW'(NXM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_DMR, ST_SACK, ST_ADDR, ST_SYNC, ST_DIN,
    ST_RDLY, ST_RWAIT, ST_DATA, ST_DOUT, ST_WWAIT, ST_END
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [21:0]   addr_q;
  logic [15:0]   wdata_q;
  logic [15:0]   rdata_q;
  logic          nxm_q;
  logic [21:0]   dal_out;
  logic          busy_c, done_c;
  logic          accept, timeout, capture;

  // State register plus datapath registers. The phase counter restarts on
  // every state change, so each timed state lasts exactly its parameter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      nxm_q   <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? '0 : cnt + 1'b1;
      if (accept) begin
        we_q    <= host.we;
        addr_q  <= host.addr;
        wdata_q <= host.wdata;
        nxm_q   <= 1'b0;
      end
      if (timeout) nxm_q   <= 1'b1;
      if (capture) rdata_q <= DAL[15:0];
    end
  end

  always_comb begin
    nxt     = state;
    dal_out = '0;
    DALtx   = 1'b0;
    TSYNC   = 1'b0;
    TDIN    = 1'b0;
    TDOUT   = 1'b0;
    TWTBT   = 1'b0;
    TDMR    = 1'b0;
    TSACK   = 1'b0;
    TDMGO   = 1'b0;
    busy_c  = 1'b1;
    done_c  = 1'b0;
    timeout = 1'b0;
    capture = 1'b0;
    accept  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy_c = 1'b0;
        TDMGO  = RDMGI;   // grant passes through only when we are not using the bus
        if (host.req) begin
          nxt    = ST_DMR;
          accept = !RINIT;
        end
      end
      ST_DMR: begin
        TDMR = 1'b1;
        if (RDMGI) nxt = ST_SACK;
      end
      ST_SACK: begin
        TSACK = 1'b1;
        // previous master must have finished its cycle
        if (!RSYNC && !RRPLY) nxt = ST_ADDR;
      end
      ST_ADDR: begin
        TSACK = 1'b1; DALtx = 1'b1; dal_out = addr_q; TWTBT = we_q;
        if (cnt == AS_LAST) nxt = ST_SYNC;
      end
      ST_SYNC: begin
        TSACK = 1'b1; TSYNC = 1'b1; DALtx = 1'b1; dal_out = addr_q; TWTBT = we_q;
        if (cnt == DK_LAST) nxt = we_q ? ST_DATA : ST_DIN;
      end
      ST_DIN: begin
        TSACK = 1'b1; TSYNC = 1'b1; TDIN = 1'b1;
        if (RRPLY) nxt = ST_RDLY;
        else if (cnt == NT_LAST) begin nxt = ST_END; timeout = 1'b1; end
      end
      ST_RDLY: begin
        TSACK = 1'b1; TSYNC = 1'b1; TDIN = 1'b1;
        if (cnt == RD_LAST) begin nxt = ST_RWAIT; capture = 1'b1; end
      end
      ST_RWAIT: begin
        TSACK = 1'b1; TSYNC = 1'b1;
        if (!RRPLY) nxt = ST_END;
      end
      ST_DATA: begin
        TSACK = 1'b1; TSYNC = 1'b1; DALtx = 1'b1; dal_out = {6'b0, wdata_q};
        if (cnt == DS_LAST) nxt = ST_DOUT;
      end
      ST_DOUT: begin
        TSACK = 1'b1; TSYNC = 1'b1; DALtx = 1'b1; dal_out = {6'b0, wdata_q}; TDOUT = 1'b1;
        if (RRPLY) nxt = ST_WWAIT;
        else if (cnt == NT_LAST) begin nxt = ST_END; timeout = 1'b1; end
      end
      ST_WWAIT: begin
        TSACK = 1'b1; TSYNC = 1'b1; DALtx = 1'b1; dal_out = {6'b0, wdata_q};
        if (!RRPLY) nxt = ST_END;
      end
      ST_END: begin
        done_c = !RINIT;
        nxt    = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
    // bus init overrides everything and suppresses any pending update
    if (RINIT) begin
      nxt     = ST_IDLE;
      timeout = 1'b0;
      capture = 1'b0;
    end
  end

  assign DAL        = DALtx ? dal_out : 'z;
  assign host.busy  = busy_c;
  assign host.done  = done_c;
  assign host.nxm   = nxm_q;
  assign host.rdata = rdata_q;

endmodule

// File: tb/tb_qbus_dma.sv
module tb_qbus_dma;
  localparam int AS = 3, DK = 2, DS = 2, RD = 3, NT = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic RRPLY = 1'b0, RSYNC = 1'b0, RDMGI = 1'b0, RINIT = 1'b0;
  logic DALtx, TSYNC, TDIN, TDOUT, TWTBT, TDMR, TSACK, TDMGO;
  logic        slv_drv = 1'b0;
  logic [21:0] slv_data = '0;
  tri   [21:0] DAL;

  qbus_dma_if bus();

  assign DAL = slv_drv ? slv_data : 'z;

  qbus_dma #(.ADDR_SETUP(AS), .DESKEW(DK), .DATA_SETUP(DS), .RPLY_DLY(RD), .NXM_TIMEOUT(NT)) dut (
    .clk(clk), .reset_n(reset_n), .host(bus), .DAL(DAL), .DALtx(DALtx),
    .RRPLY(RRPLY), .RSYNC(RSYNC), .RDMGI(RDMGI), .RINIT(RINIT),
    .TSYNC(TSYNC), .TDIN(TDIN), .TDOUT(TDOUT), .TWTBT(TWTBT),
    .TDMR(TDMR), .TSACK(TSACK), .TDMGO(TDMGO)
  );

  always #5 clk = ~clk;

  wire [8:0] act9 = {bus.busy, bus.done, DALtx, TSYNC, TDIN, TDOUT, TWTBT, TDMR, TSACK};

  typedef struct {
    logic        we;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd;
    logic        resp;
    int          gdly;
    int          sh;
    logic [15:0] exp_rdata;
    logic        exp_nxm;
  } vec_t;

  vec_t vecs[9];

  int checks = 0, failures = 0, inv_err = 0;
  int cyc = 0;
  int a_cyc, s_cyc, d_cyc, o_cyc, t_cyc, e_cyc, r_cyc, rd_cyc;
  int done_n, twtbt_n, tdmr_n, rply_wait, sync_left;
  logic [21:0] addr_seen;
  logic [15:0] data_seen;
  logic        nxm_seen;
  logic        cur_we, cur_resp, chk_rd;
  logic [15:0] cur_rd, cur_exp_rd;
  int          cur_gdly, cur_sh;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: observe DUT outputs 1ns after the edge, then act as the
  // arbiter / previous master / memory slave for the next edge.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (TDIN && DALtx) inv_err++;
    if (TDMR && TSACK) inv_err++;
    if (TSYNC && RSYNC) inv_err++;
    if (bus.busy ? TDMGO : (TDMGO !== RDMGI)) inv_err++;
    if (DALtx && a_cyc < 0) a_cyc = cyc;
    if (TSYNC && s_cyc < 0) begin s_cyc = cyc; addr_seen = DAL; end
    if (cur_we && TSYNC && DALtx && !TWTBT && !TDOUT && d_cyc < 0) d_cyc = cyc;
    if (TDOUT && o_cyc < 0) begin o_cyc = cyc; data_seen = DAL[15:0]; end
    if ((TDIN || TDOUT) && t_cyc < 0) t_cyc = cyc;
    if (TWTBT) twtbt_n++;
    if (bus.done) begin
      done_n++;
      if (e_cyc < 0) begin e_cyc = cyc; nxm_seen = bus.nxm; end
    end
    if (chk_rd && rd_cyc < 0 && bus.rdata == cur_exp_rd) rd_cyc = cyc;
    // arbiter and previous bus master
    if (TSACK) RDMGI = 1'b0;
    else if (TDMR) begin
      if (tdmr_n >= cur_gdly && !RDMGI) begin RDMGI = 1'b1; sync_left = cur_sh; end
      tdmr_n++;
    end
    if (sync_left > 0) begin RSYNC = 1'b1; sync_left--; end
    else RSYNC = 1'b0;
    // memory slave, replies two clocks after TDIN/TDOUT
    if (TDIN || TDOUT) begin
      if (cur_resp) begin
        if (rply_wait >= 2) begin
          if (!RRPLY) r_cyc = cyc;
          RRPLY = 1'b1;
          if (TDIN) begin slv_drv = 1'b1; slv_data = {6'b0, cur_rd}; end
        end
        rply_wait++;
      end
    end else begin
      RRPLY = 1'b0; slv_drv = 1'b0; rply_wait = 0;
    end
  endtask

  task automatic start_xfer(input vec_t v);
    a_cyc = -1; s_cyc = -1; d_cyc = -1; o_cyc = -1; t_cyc = -1; e_cyc = -1; r_cyc = -1; rd_cyc = -1;
    done_n = 0; twtbt_n = 0; tdmr_n = 0; rply_wait = 0; sync_left = 0;
    RDMGI = 1'b0; RSYNC = 1'b0;
    addr_seen = '0; data_seen = '0; nxm_seen = 1'b0;
    cur_we = v.we; cur_resp = v.resp; cur_rd = v.rd; cur_gdly = v.gdly; cur_sh = v.sh;
    cur_exp_rd = v.exp_rdata; chk_rd = !v.we && v.resp;
    bus.req = 1'b1; bus.we = v.we; bus.addr = v.addr; bus.wdata = v.wdata;
    step();
    bus.req = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    start_xfer(v);
    for (int k = 0; k < 400 && e_cyc < 0; k++) step();
    step(); step();
    chk($sformatf("v%0d_done_count", i), done_n, 1);
    chk($sformatf("v%0d_nxm", i), nxm_seen, v.exp_nxm);
    chk($sformatf("v%0d_rdata", i), bus.rdata, v.exp_rdata);
    chk($sformatf("v%0d_addr_on_dal", i), addr_seen, v.addr);
    chk($sformatf("v%0d_addr_setup", i), s_cyc - a_cyc, AS);
    chk($sformatf("v%0d_twtbt_clocks", i), twtbt_n, v.we ? AS + DK : 0);
    if (v.we) chk($sformatf("v%0d_data_setup", i), o_cyc - d_cyc, DS);
    if (v.we && v.resp) chk($sformatf("v%0d_wdata_on_dal", i), data_seen, v.wdata);
    if (!v.we && v.resp) chk($sformatf("v%0d_rply_dly", i), rd_cyc - r_cyc - 1, RD);
    if (!v.resp) chk($sformatf("v%0d_nxm_time", i), e_cyc - t_cyc, NT);
    chk($sformatf("v%0d_idle_after", i), act9, 9'b0);
  endtask

  task automatic wait_for_strobe(input string nm, input logic is_dout);
    int k;
    k = 0;
    while (!(is_dout ? TDOUT : TDIN) && k < 200) begin step(); k++; end
    chk(nm, (is_dout ? TDOUT : TDIN), 1'b1);
    step(); step();
  endtask

  initial begin
    //            we    addr            wdata         rd            resp  gdly sh  exp_rdata     exp_nxm
    vecs[0] = '{1'b0, 22'o17777774, 16'h0000,     16'o123456,   1'b1, 0,   0,  16'o123456,   1'b0};
    vecs[1] = '{1'b1, 22'o17777772, 16'o054321,   16'h0000,     1'b1, 0,   0,  16'o123456,   1'b0};
    vecs[2] = '{1'b0, 22'o17777770, 16'h0000,     16'h0000,     1'b0, 0,   0,  16'o123456,   1'b1};
    vecs[3] = '{1'b0, 22'o00001000, 16'h0000,     16'o000777,   1'b1, 50,  20, 16'o000777,   1'b0};
    vecs[4] = '{1'b1, 22'o17000000, 16'hFFFF,     16'h0000,     1'b1, 5,   3,  16'o000777,   1'b0};
    vecs[5] = '{1'b1, 22'h000000,   16'h1234,     16'h0000,     1'b0, 0,   0,  16'o000777,   1'b1};
    vecs[6] = '{1'b0, 22'h3FFFFE,   16'h0000,     16'hA5A5,     1'b1, 2,   1,  16'hA5A5,     1'b0};
    vecs[7] = '{1'b1, 22'h155554,   16'h5AA5,     16'h0000,     1'b1, 0,   0,  16'hA5A5,     1'b0};
    vecs[8] = '{1'b0, 22'h2AAAAA,   16'h0000,     16'h0F0F,     1'b1, 0,   0,  16'h0F0F,     1'b0};

    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    cur_we = 1'b0; cur_resp = 1'b0; chk_rd = 1'b0; cur_gdly = 0; cur_sh = 0;
    cur_rd = '0; cur_exp_rd = '0;
    a_cyc = -1; s_cyc = -1; d_cyc = -1; o_cyc = -1; t_cyc = -1; e_cyc = -1; r_cyc = -1; rd_cyc = -1;
    done_n = 0; twtbt_n = 0; tdmr_n = 0; rply_wait = 0; sync_left = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.nxm, act9, TDMGO}, 11'b0);
    chk("reset_rdata", bus.rdata, 16'h0);
    reset_n = 1'b1;
    step();

    // grant pass-through while idle
    RDMGI = 1'b1; #1;
    chk("tdmgo_idle_high", TDMGO, 1'b1);
    RDMGI = 1'b0; #1;
    chk("tdmgo_idle_low", TDMGO, 1'b0);

    for (int i = 0; i < 7; i++) run_vec(i);

    // RINIT in the middle of DOUT (no responder, so DOUT is held)
    start_xfer('{1'b1, 22'h001234, 16'hBEEF, 16'h0, 1'b0, 0, 0, 16'hA5A5, 1'b0});
    wait_for_strobe("rinit_reach_dout", 1'b1);
    done_n = 0;
    RINIT = 1'b1;
    step();
    RINIT = 1'b0;
    chk("rinit_outputs_zero", {act9, TDMGO}, 10'b0);
    repeat (5) step();
    chk("rinit_no_done", done_n, 0);
    run_vec(7);

    // reset_n in the middle of DIN
    start_xfer('{1'b0, 22'h004321, 16'h0, 16'h0, 1'b0, 0, 0, 16'h0, 1'b0});
    wait_for_strobe("reset_reach_din", 1'b0);
    done_n = 0;
    reset_n = 1'b0; #1;
    chk("reset_mid_outputs_zero", {act9, TDMGO, bus.nxm}, 11'b0);
    reset_n = 1'b1;
    repeat (5) step();
    chk("reset_mid_no_done", done_n, 0);
    run_vec(8);

    chk("bus_invariants", inv_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qbus_dma.md
QBUS_DMA -- requirements
Module: qbus_dma

Interface
REQ-001 Parameter ADDR_SETUP, default 15: clocks address is driven on DAL before TSYNC asserts.
REQ-002 Parameter DESKEW, default 10: clocks address is held after TSYNC asserts.
REQ-003 Parameter DATA_SETUP, default 10: clocks write data is driven before TDOUT asserts.
REQ-004 Parameter RPLY_DLY, default 15: clocks from RRPLY sampled high to read-data capture.
REQ-005 Parameter NXM_TIMEOUT, default 1000: clocks waited for RRPLY before declaring NXM.
REQ-006 Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  start one transfer; sampled only in IDLE.
- we  in  1  1 = DATO write, 0 = DATI read; sampled with req.
- addr  in  22  bus byte address; sampled with req.
- wdata  in  16  write data; sampled with req.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-clock pulse when a transfer ends.
- nxm  out  1  valid with done; 1 = timed out.
- rdata  out  16  read data; valid from done until the next accepted req.
- DAL  inout  22  shared FPGA-side DAL; driven only while DALtx = 1, else high-Z.
- DALtx  out  1  DAL direction, 1 = FPGA drives the bus.
- RRPLY, RSYNC, RDMGI, RINIT  in  1 each  received bus signals, active-high.
- TSYNC, TDIN, TDOUT, TWTBT, TDMR, TSACK, TDMGO  out  1 each  transmitted bus signals, active-high.

Function
REQ-007 The block SHALL accept req only in IDLE and latch we, addr and wdata in the same clock.
REQ-008 The state machine SHALL have these states: IDLE, DMR, SACK, ADDR, SYNC, DIN, RDLY, RWAIT, DATA, DOUT, WWAIT, END.
REQ-009 DMR: the block SHALL assert TDMR and wait for RDMGI = 1.
REQ-010 SACK: the block SHALL assert TSACK, negate TDMR, and wait until RSYNC = 0 and RRPLY = 0.
REQ-011 ADDR: the block SHALL drive DAL = addr with DALtx = 1 and TWTBT = we for ADDR_SETUP clocks.
REQ-012 SYNC: the block SHALL assert TSYNC and hold the address for DESKEW clocks, then negate TWTBT.
REQ-013 A read SHALL enter DIN. DIN: the block SHALL negate DALtx, assert TDIN and wait for RRPLY.
REQ-014 RDLY: the block SHALL wait RPLY_DLY clocks, then latch DAL[15:0] into rdata.
REQ-015 RWAIT: the block SHALL negate TDIN and wait for RRPLY = 0, then go to END.
REQ-016 A write SHALL enter DATA. DATA: the block SHALL drive DAL = {6'b0, wdata} for DATA_SETUP clocks.
REQ-017 DOUT: the block SHALL assert TDOUT and wait for RRPLY.
REQ-018 WWAIT: the block SHALL negate TDOUT, keep the data driven until RRPLY = 0, then go to END.
REQ-019 END: the block SHALL negate TSYNC, TSACK and DALtx, pulse done for one clock and return to IDLE.
REQ-020 A counter of at least 10 bits SHALL count clocks in DIN and DOUT.
- When it reaches NXM_TIMEOUT, the block SHALL negate TDIN/TDOUT, set nxm = 1 and go to END.
- rdata SHALL be unchanged on a read NXM.
REQ-021 TDMGO SHALL equal RDMGI while in IDLE.
- In any other state, TDMGO SHALL be 0: the block consumes the grant and does not pass it on.
REQ-022 DALtx SHALL never be 1 while TDIN = 1.
REQ-023 RINIT = 1 in any state SHALL return the block to IDLE within one clock.
- All T* outputs and DALtx SHALL be 0.
- done SHALL not pulse.
REQ-024 All received signals SHALL be treated as already synchronous to clk; this block adds no synchronizers.

Reset
REQ-025 While reset_n = 0, the block SHALL be in IDLE with every output 0 and DAL high-Z.
REQ-026 Reset asserted during a transfer SHALL abort it immediately and produce no done pulse.

Verification
REQ-027 Read: req, we = 0, addr = 'o17777774; slave replies 'o123456 -> rdata = 'o123456, done = 1, nxm = 0, TSYNC = 0 afterwards.
REQ-028 Write: req, we = 1, addr = 'o17777772, wdata = 'o054321 -> slave latches 'o054321 on TDOUT; TWTBT = 1 only across ADDR/SYNC; done = 1.
REQ-029 NXM: read of 'o17777770 with no responder -> done with nxm = 1 exactly NXM_TIMEOUT clocks after TDIN; TDIN = 0 afterwards.
REQ-030 Arbitration: RDMGI held off 50 clocks, and RSYNC held high 20 clocks after the grant -> no TSYNC before RSYNC = 0; TDMR drops once TSACK is asserted; TDMGO = RDMGI while idle.
REQ-031 Abort: RINIT pulsed mid-DOUT, and separately reset_n pulsed mid-DIN -> all outputs 0 next clock, no done pulse, next req completes normally.
REQ-032 Timing check: ADDR_SETUP clocks from DAL address to TSYNC; DATA_SETUP clocks from data to TDOUT; rdata sampled exactly RPLY_DLY clocks after RRPLY.
